// File: rtl/response_tally_pkg.sv
// -----------------------------------------------------------------------------
// response_tally_pkg
//
// Shared definitions for the response tally block:
//   - geometry of the response vector, counters and readback index
//   - MISR polynomial and seed
//   - collection FSM state encoding
//   - MISR next-state function (one step per accepted response vector)
// -----------------------------------------------------------------------------
package response_tally_pkg;

   // Response vector width; bit OUT_W-1 carries o1, bit 0 carries o22.
   localparam int OUT_W = 22;

   // Width of the sample counter, the window length and every ones counter.
   localparam int CNT_W = 16;

   // Readback index width; wide enough to address every response bit.
   localparam int IDX_W = 5;

   // MISR feedback taps for x^32 + x^22 + x^2 + x + 1 (x^32 term implicit).
   localparam logic [31:0] POLY = 32'h0040_0007;

   // MISR value loaded whenever a new window starts.
   localparam logic [31:0] SEED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      FINALIZE = 2'd2,
      DONE     = 2'd3
   } state_e;

   // One MISR step: shift left with polynomial feedback from the bit that
   // falls off the top, then fold in the zero-extended response vector.
   function automatic logic [31:0] misr_next(input logic [31:0]      sig,
                                             input logic [OUT_W-1:0] data);
      logic [31:0] shifted;
      shifted = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0000_0000);
      return shifted ^ {{(32-OUT_W){1'b0}}, data};
   endfunction

endpackage : response_tally_pkg

// File: rtl/response_tally_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
//
// Ones counter for a single response bit. Clear wins over increment so a
// window restart discards a sample presented in the same cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear to zero
//   inc    in   add one this cycle (ignored while clr is high)
//   cnt    out  current count
// -----------------------------------------------------------------------------
module bit_counter
   import response_tally_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // The count can never exceed the window length, so no saturation is needed.
   // NOTE: every signal written in always_comb gets a default on the first
   // line so that no path leaves it unassigned and a latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the values computed before the edge regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : bit_counter

// File: rtl/response_tally.sv
// -----------------------------------------------------------------------------
// response_tally
//
// Collects a programmable window of response vectors from the circuit under
// test and condenses them into per-bit ones counts, a majority bias vector
// and a 32-bit MISR signature for the statistical key-recovery flow.
//
// Ports:
//   v_in1_v     in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle pulse: latch window_len, clear, start collecting
//   window_len  in   samples to accept in the window (sampled on start)
//   resp_valid  in   resp_data is valid this cycle
//   resp_data   in   response vector (bit OUT_W-1 = o1, bit 0 = o22)
//   resp_ready  out  a sample is accepted this cycle if resp_valid is high
//   busy        out  high while collecting or finalizing
//   done        out  one-cycle pulse on entry to DONE
//   sample_cnt  out  samples accepted in the current window
//   signature   out  MISR state
//   bias_vec    out  per-bit majority flag (ones_count*2 > window), valid in DONE
//   rd_idx      in   index of the ones counter to read back
//   rd_count    out  registered ones count for rd_idx (0 when out of range)
// -----------------------------------------------------------------------------
module response_tally
   import response_tally_pkg::*;
(
   input  logic             v_in1_v,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] window_len,
   input  logic             resp_valid,
   input  logic [OUT_W-1:0] resp_data,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [31:0]      signature,
   output logic [OUT_W-1:0] bias_vec,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CNT_W-1:0] rd_count
);

   state_e           state_d,      state_q;
   logic [CNT_W-1:0] win_d,        win_q;
   logic [CNT_W-1:0] sample_cnt_d, sample_cnt_q;
   logic [31:0]      sig_d,        sig_q;
   logic [OUT_W-1:0] bias_d,       bias_q;
   logic [CNT_W-1:0] rd_count_d,   rd_count_q;
   logic             done_d,       done_q;

   logic             accept;
   logic [CNT_W-1:0] ones_cnt [OUT_W];

   // Ready depends on state alone so the upstream handshake has no
   // combinational loop through resp_valid.
   assign resp_ready = (state_q == COLLECT);
   assign busy       = (state_q == COLLECT) || (state_q == FINALIZE);

   // A start in the same cycle as a valid sample restarts the window and
   // drops that sample.
   assign accept = resp_ready & resp_valid & ~start;

   // ---------------------------------------------------------------------------
   // Per-bit ones counters. start clears them in every state, matching the
   // clearing of the window-level registers below.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < OUT_W; i++) begin : gen_bit
      bit_counter u_cnt (
         .clk   (v_in1_v),
         .rst_n (reset),
         .clr   (start),
         .inc   (accept & resp_data[i]),
         .cnt   (ones_cnt[i])
      );
   end

   // ---------------------------------------------------------------------------
   // Collection FSM, sample counter, MISR and bias computation.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      sample_cnt_d = sample_cnt_q;
      sig_d        = sig_q;
      bias_d       = bias_q;
      done_d       = 1'b0;

      if (start) begin
         // Same clearing from any state; an aborted window raises no done.
         win_d        = window_len;
         sample_cnt_d = '0;
         sig_d        = SEED;
         bias_d       = '0;
         state_d      = (window_len == '0) ? FINALIZE : COLLECT;
      end else begin
         unique case (state_q)
            IDLE: begin
            end

            COLLECT: begin
               if (resp_valid) begin
                  sample_cnt_d = sample_cnt_q + CNT_W'(1);
                  sig_d        = misr_next(sig_q, resp_data);
                  // The sample that fills the window is still counted.
                  if (sample_cnt_d == win_q) begin
                     state_d = FINALIZE;
                  end
               end
            end

            FINALIZE: begin
               // Doubling the count is compared against the window with one
               // extra bit so an exact tie (count*2 == window) is not a majority.
               for (int i = 0; i < OUT_W; i++) begin
                  bias_d[i] = ({ones_cnt[i], 1'b0} > {1'b0, win_q});
               end
               state_d = DONE;
               done_d  = 1'b1;
            end

            DONE: begin
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Readback mux: out-of-range indices read as zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_count_d = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_count_d = ones_cnt[i];
         end
      end
   end

   always_ff @(posedge v_in1_v or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         win_q        <= '0;
         sample_cnt_q <= '0;
         sig_q        <= '0;
         bias_q       <= '0;
         rd_count_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         sample_cnt_q <= sample_cnt_d;
         sig_q        <= sig_d;
         bias_q       <= bias_d;
         rd_count_q   <= rd_count_d;
         done_q       <= done_d;
      end
   end

   assign done       = done_q;
   assign sample_cnt = sample_cnt_q;
   assign signature  = sig_q;
   assign bias_vec   = bias_q;
   assign rd_count   = rd_count_q;

endmodule : response_tally

// File: tb/tb_response_tally.sv
// -----------------------------------------------------------------------------
// tb_response_tally
//
// Directed and randomized stimulus for response_tally. The reference model
// keeps the accepted response vectors of the current window in a queue and
// derives counts, bias and signature from that list directly.
// -----------------------------------------------------------------------------
module tb_response_tally;

   localparam int          OUT_W  = 22;
   localparam int          CNT_W  = 16;
   localparam int          IDX_W  = 5;
   localparam logic [31:0] POLY_C = 32'h0040_0007;
   localparam logic [31:0] SEED_C = 32'hFFFF_FFFF;

   logic             clk        = 1'b0;
   logic             reset      = 1'b0;
   logic             start      = 1'b0;
   logic [CNT_W-1:0] window_len = '0;
   logic             resp_valid = 1'b0;
   logic [OUT_W-1:0] resp_data  = '0;
   logic [IDX_W-1:0] rd_idx     = '0;
   logic             resp_ready;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sample_cnt;
   logic [31:0]      signature;
   logic [OUT_W-1:0] bias_vec;
   logic [CNT_W-1:0] rd_count;

   response_tally dut (
      .v_in1_v    (clk),
      .reset      (reset),
      .start      (start),
      .window_len (window_len),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .busy       (busy),
      .done       (done),
      .sample_cnt (sample_cnt),
      .signature  (signature),
      .bias_vec   (bias_vec),
      .rd_idx     (rd_idx),
      .rd_count   (rd_count)
   );

   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model state for the current window.
   logic [OUT_W-1:0] acc_q [$];
   int               model_win  = 0;
   bit               collecting = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_count(input int k);
      int n;
      n = 0;
      if (k < OUT_W) begin
         foreach (acc_q[j]) n += int'(acc_q[j][k]);
      end
      return n;
   endfunction

   function automatic logic [OUT_W-1:0] model_bias();
      logic [OUT_W-1:0] b;
      b = '0;
      for (int k = 0; k < OUT_W; k++) b[k] = (model_count(k) * 2 > model_win);
      return b;
   endfunction

   // Polynomial signature: multiply by x modulo POLY, then add the sample.
   function automatic logic [31:0] model_sig();
      logic [31:0] s;
      s = SEED_C;
      foreach (acc_q[k]) begin
         s = s[31] ? ((s << 1) ^ POLY_C) : (s << 1);
         s = s ^ {{(32-OUT_W){1'b0}}, acc_q[k]};
      end
      return s;
   endfunction

   task automatic start_window(input int len, input bit with_valid,
                               input logic [OUT_W-1:0] data);
      start      = 1'b1;
      window_len = CNT_W'(len);
      resp_valid = with_valid;
      resp_data  = data;
      tick();
      start      = 1'b0;
      resp_valid = 1'b0;
      acc_q.delete();
      model_win  = len;
      collecting = (len > 0);
      check("start_sample_cnt", sample_cnt, 0);
      check("start_done", done, 0);
      check("start_ready", resp_ready, collecting);
      check("start_busy", busy, 1);
      check("start_sig", signature, SEED_C);
      check("start_bias", bias_vec, 0);
   endtask

   task automatic send(input logic [OUT_W-1:0] data, input bit valid);
      resp_valid = valid;
      resp_data  = data;
      check("ready_pre", resp_ready, collecting);
      tick();
      resp_valid = 1'b0;
      if (valid && collecting) begin
         acc_q.push_back(data);
         if (acc_q.size() == model_win) collecting = 1'b0;
      end
      check("sample_cnt", sample_cnt, acc_q.size());
      check("signature", signature, model_sig());
      check("done_low", done, 0);
   endtask

   task automatic read_check(input int idx);
      rd_idx = IDX_W'(idx);
      tick();
      check($sformatf("rd_count[%0d]", idx), rd_count, model_count(idx));
   endtask

   // Called one cycle after the last accept (or after a zero-length start).
   task automatic finish_window();
      check("fin_ready", resp_ready, 0);
      check("fin_busy", busy, 1);
      check("fin_done", done, 0);
      tick();
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_ready", resp_ready, 0);
      check("done_bias", bias_vec, model_bias());
      check("done_sig", signature, model_sig());
      check("done_cnt", sample_cnt, model_win);
      tick();
      check("done_single", done, 0);
      check("held_bias", bias_vec, model_bias());
      read_check(0);
      read_check(OUT_W - 1);
      read_check(int'($urandom_range(0, 31)));
   endtask

   task automatic run_random(input int len);
      int c;
      start_window(len, 1'b0, '0);
      c = 0;
      while (collecting && c < 200) begin
         send(OUT_W'($urandom), (c > 20) || ($urandom_range(0, 1) == 1));
         c++;
      end
      finish_window();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #12;
      check("rst_ready", resp_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", sample_cnt, 0);
      check("rst_sig", signature, 0);
      check("rst_bias", bias_vec, 0);
      check("rst_rd", rd_count, 0);
      tick();
      reset = 1'b1;
      tick();
      check("idle_ready", resp_ready, 0);
      check("idle_busy", busy, 0);

      // Basic window of four samples
      start_window(4, 1'b0, '0);
      send(22'h3FFFFF, 1'b1);
      send(22'h000000, 1'b1);
      send(22'h3FFFFF, 1'b1);
      send(22'h200001, 1'b1);
      finish_window();
      check("basic_bias", bias_vec, 22'h200001);
      rd_idx = 5'd0;
      tick();
      check("basic_rd0", rd_count, 3);
      rd_idx = 5'd21;
      tick();
      check("basic_rd21", rd_count, 3);
      rd_idx = 5'd5;
      tick();
      check("basic_rd5", rd_count, 2);

      // Valid gaps: 1,0,0,1,0,1 gives exactly three accepts
      start_window(3, 1'b0, '0);
      send(OUT_W'($urandom), 1'b1);
      send(OUT_W'($urandom), 1'b0);
      send(OUT_W'($urandom), 1'b0);
      send(OUT_W'($urandom), 1'b1);
      send(OUT_W'($urandom), 1'b0);
      send(OUT_W'($urandom), 1'b1);
      finish_window();

      // Zero-length window
      start_window(0, 1'b0, '0);
      finish_window();
      check("zero_sig", signature, 32'hFFFF_FFFF);
      check("zero_bias", bias_vec, 0);
      check("zero_cnt", sample_cnt, 0);

      // Restart mid-window with a simultaneous valid sample
      start_window(10, 1'b0, '0);
      for (int i = 0; i < 6; i++) send(OUT_W'($urandom), 1'b1);
      start_window(2, 1'b1, OUT_W'($urandom));
      send(OUT_W'($urandom), 1'b1);
      send(OUT_W'($urandom), 1'b1);
      finish_window();

      // Majority tie on bit 0 and out-of-range readback
      start_window(2, 1'b0, '0);
      send(22'h000001, 1'b1);
      send(22'h000000, 1'b1);
      finish_window();
      check("tie_bias0", bias_vec[0], 0);
      rd_idx = 5'd22;
      tick();
      check("rd_out_of_range", rd_count, 0);

      // Randomized windows
      for (int w = 0; w < 8; w++) run_random(int'($urandom_range(1, 12)));

      // Asynchronous reset after five samples of a ten-sample window
      start_window(10, 1'b0, '0);
      for (int i = 0; i < 5; i++) send(OUT_W'($urandom), 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_ready", resp_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_cnt", sample_cnt, 0);
      check("mid_rst_sig", signature, 0);
      check("mid_rst_bias", bias_vec, 0);
      check("mid_rst_rd", rd_count, 0);
      tick();
      reset = 1'b1;
      acc_q.delete();
      collecting = 1'b0;
      for (int i = 0; i < 3; i++) begin
         resp_valid = 1'b1;
         resp_data  = OUT_W'($urandom);
         check("post_rst_ready", resp_ready, 0);
         tick();
         check("post_rst_cnt", sample_cnt, 0);
         check("post_rst_busy", busy, 0);
      end
      resp_valid = 1'b0;
      rd_idx = 5'd0;
      tick();
      check("post_rst_rd", rd_count, 0);

      // Normal operation resumes after reset
      run_random(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_response_tally
